alu_op_sequencer: RTL and testbench

- Sequencing controller for the 4-bit FPGA ALU (ops 0..6: add, sub, shr, shl, and, or, xor).
- Latches operands and opcode from switches and drives the ALU inputs.
- Waits a settle time, then registers result and flags, masking flags by operation.
- Auto mode steps through all seven ops with a visible dwell per op for the 7-segment display path.

---
 rtl/alu_ctrl_pkg.sv | 50 +++++
 rtl/dwell_counter.sv | 28 ++
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the 4-bit ALU sequencing controller.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_EXEC    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_LAST = 3'd6;

  localparam int NUM_OPS = 7;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic is_valid_op(input logic [2:0] op);
    return op <= OP_LAST;
  endfunction

  // Carry/overflow only mean something for add, negative only for sub;
  // zero comes from the result itself rather than the ALU's Z flag.
  function automatic flags_t mask_flags(input logic [2:0] op,
                                        input logic       zero,
                                        input logic       n,
                                        input logic       c,
                                        input logic       v);
    flags_t f;
    f.z = zero;
    f.n = (op == OP_SUB) && n;
    f.c = (op == OP_ADD) && c;
    f.v = (op == OP_ADD) && v;
    return f;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Cycle counter that flags the MAX-th consecutive enabled cycle since load.
module dwell_counter #(
  parameter int MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (enable && !expired)
      cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the ALU from latched switches, waits for it to settle, captures
// result and masked flags; auto mode walks ops 0..6 with a dwell per op.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2,
  parameter int DWELL  = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             auto_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic [WIDTH-1:0] result,
  output logic             n_out,
  output logic             z_out,
  output logic             c_out,
  output logic             v_out,
  output logic [2:0]       op_cur,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t state, state_next;
  logic   auto_q;
  flags_t flags;
  logic   kill;
  logic   load_invalid;
  logic   settle_exp;
  logic   dwell_exp;
  logic   in_exec;
  logic   in_hold;

  assign kill         = abort && (state != S_IDLE);
  assign load_invalid = !auto_q && !is_valid_op(op_in);
  assign in_exec      = (state == S_EXEC);
  assign in_hold      = (state == S_HOLD);

  // Counters are held cleared outside their own state, so every entry starts at zero.
  dwell_counter #(.MAX(SETTLE)) u_settle (
    .clk     (clk),
    .rst     (rst),
    .load    (!in_exec),
    .enable  (in_exec),
    .expired (settle_exp)
  );

  dwell_counter #(.MAX(DWELL)) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .load    (!in_hold),
    .enable  (in_hold),
    .expired (dwell_exp)
  );

  // NOTE: non-blocking assignment so every flop samples pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_LOAD;
      S_LOAD:    state_next = load_invalid ? S_DONE : S_EXEC;
      S_EXEC:    if (settle_exp) state_next = S_CAPTURE;
      S_CAPTURE: state_next = auto_q ? S_HOLD : S_DONE;
      S_HOLD:    if (dwell_exp) state_next = (alu_op < OP_LAST) ? S_EXEC : S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (kill)
      state_next = S_IDLE;
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // NOTE: every datapath register is reset, so all outputs read zero straight out of rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q <= 1'b0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      result <= '0;
      flags  <= '0;
      op_cur <= '0;
      err    <= 1'b0;
    end else if (!kill) begin
      case (state)
        S_IDLE: begin
          if (start)
            auto_q <= auto_mode;
        end
        S_LOAD: begin
          alu_a  <= a_in;
          alu_b  <= b_in;
          alu_op <= auto_q ? OP_ADD : op_in;
          err    <= 1'b0;
          if (load_invalid) begin
            err    <= 1'b1;
            result <= '0;
            flags  <= '0;
            op_cur <= op_in;
          end
        end
        S_CAPTURE: begin
          result <= alu_res;
          op_cur <= alu_op;
          flags  <= mask_flags(alu_op, alu_res == '0, alu_n, alu_c, alu_v);
        end
        S_HOLD: begin
          if (dwell_exp && (alu_op < OP_LAST))
            alu_op <= alu_op + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign n_out = flags.n;
  assign z_out = flags.z;
  assign c_out = flags.c;
  assign v_out = flags.v;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;

  localparam int W      = 4;
  localparam int S      = 2;
  localparam int D      = 4;
  localparam int PERIOD = S + D + 1;
  localparam int MODV   = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         auto_mode = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [2:0]   op_in = '0;
  logic [W-1:0] alu_a, alu_b, alu_res, result;
  logic [2:0]   alu_op, op_cur;
  logic         alu_n, alu_c, alu_v;
  logic         n_out, z_out, c_out, v_out, busy, done, err;
  logic [W:0]   sum;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W), .SETTLE(S), .DWELL(D)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_mode(auto_mode), .abort(abort),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .result(result), .n_out(n_out), .z_out(z_out), .c_out(c_out), .v_out(v_out),
    .op_cur(op_cur), .busy(busy), .done(done), .err(err)
  );

  // Behavioural ALU; irrelevant flags are driven high so masking is exercised.
  always_comb begin
    sum     = {1'b0, alu_a} + {1'b0, alu_b};
    alu_res = '0;
    alu_n   = 1'b1;
    alu_c   = 1'b1;
    alu_v   = 1'b1;
    case (alu_op)
      3'd0: begin alu_res = sum[W-1:0]; alu_c = sum[W]; alu_v = sum[W]; end
      3'd1: begin
        if (alu_a >= alu_b) begin alu_res = alu_a - alu_b; alu_n = 1'b0; end
        else alu_res = alu_b - alu_a;
      end
      3'd2: alu_res = alu_a >> 1;
      3'd3: alu_res = alu_a << 1;
      3'd4: alu_res = alu_a & alu_b;
      3'd5: alu_res = alu_a | alu_b;
      3'd6: alu_res = alu_a ^ alu_b;
      default: alu_res = '0;
    endcase
  end

  typedef struct {
    int res;
    bit n, z, c, v;
    int op;
    bit err;
    bit done;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_op_cur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected capture from the operation's arithmetic definition.
  function automatic exp_t model(input int a, input int b, input int op, input int cyc, input bit dn);
    exp_t e;
    e.res = 0; e.n = 0; e.z = 0; e.c = 0; e.v = 0; e.err = 0;
    e.op = op; e.done = dn; e.cyc = cyc;
    case (op)
      0: begin e.res = (a + b) % MODV; e.c = (a + b) >= MODV; e.v = e.c; end
      1: begin e.res = (a >= b) ? a - b : b - a; e.n = (a < b); end
      2: e.res = a / 2;
      3: e.res = (a * 2) % MODV;
      4: e.res = a & b;
      5: e.res = a | b;
      6: e.res = a ^ b;
      default: e.err = 1;
    endcase
    e.z = (op < 7) && (e.res == 0);
    return e;
  endfunction

  // Monitor: an output event is a done pulse or a change of captured values while busy.
  initial begin
    logic        prev_busy;
    logic [10:0] snap, prev_snap;
    int          cyc;
    exp_t        e;
    prev_busy = 1'b0;
    prev_snap = '0;
    cyc = 0;
    forever begin
      @(negedge clk);
      snap = {result, n_out, z_out, c_out, v_out, op_cur};
      if (busy === 1'b1 && prev_busy !== 1'b1) cyc = 1;
      else if (busy === 1'b1) cyc++;
      if (done === 1'b1 || (busy === 1'b1 && snap !== prev_snap)) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("result", result, e.res);
          check("flags_nzcv", {n_out, z_out, c_out, v_out}, {e.n, e.z, e.c, e.v});
          check("op_cur", op_cur, e.op);
          check("err", err, e.err);
          check("done", done, e.done);
          check("event_cycle", cyc, e.cyc);
        end
      end
      prev_snap = snap;
      prev_busy = busy;
    end
  end

  task automatic wiggle();
    a_in      = W'($urandom);
    b_in      = W'($urandom);
    op_in     = 3'($urandom);
    auto_mode = 1'($urandom);
  endtask

  task automatic wait_busy();
    int t = 0;
    do begin @(negedge clk); t++; end while (busy !== 1'b1 && t < 8);
    check("busy_rise", busy, 1);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (q.size() != 0 && t < budget) begin
      @(negedge clk);
      wiggle();
      t++;
    end
    check("queue_drained", q.size(), 0);
    q.delete();
    @(negedge clk);
    check("idle_after_run", busy, 0);
  endtask

  task automatic single_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    a_in = a; b_in = b; op_in = op; auto_mode = 1'b0; start = 1'b1;
    q.push_back(model(a, b, op, (op == 3'd7) ? 2 : 3 + S, 1'b1));
    wait_busy();
    start = 1'b0;
    drain(60);
    last_op_cur = op;
  endtask

  task automatic start_held(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int t = 0;
    a_in = a; b_in = b; op_in = op; auto_mode = 1'b0; start = 1'b1;
    q.push_back(model(a, b, op, 3 + S, 1'b1));
    q.push_back(model(a, b, op, 3 + S, 1'b1));
    do begin @(negedge clk); t++; end while (done !== 1'b1 && t < 40);
    check("held_first_done", done, 1);
    @(negedge clk);
    check("held_idle_gap", busy, 0);
    @(negedge clk);
    check("held_restart", busy, 1);
    start = 1'b0;
    drain(60);
    last_op_cur = op;
  endtask

  // abort_op 0..6 aborts in the HOLD of that op; 7 runs to completion.
  task automatic auto_run(input logic [W-1:0] a, input logic [W-1:0] b, input int abort_op);
    int   last;
    int   n;
    exp_t ek;
    if (last_op_cur == 0) single_run(W'($urandom), W'($urandom), 3'd7);
    last = (abort_op < 7) ? abort_op : 6;
    a_in = a; b_in = b; op_in = 3'($urandom); auto_mode = 1'b1; start = 1'b1;
    for (int k = 0; k <= last; k++) q.push_back(model(a, b, k, 3 + S + k * PERIOD, 1'b0));
    if (abort_op >= 7) q.push_back(model(a, b, 6, 3 + S + 6 * PERIOD + D, 1'b1));
    wait_busy();
    start = 1'b0;
    if (abort_op < 7) begin
      n  = 3 + S + abort_op * PERIOD + 1;
      ek = model(a, b, abort_op, 0, 1'b0);
      for (int c = 1; c < n; c++) begin @(negedge clk); wiggle(); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, ek.res);
      repeat (3) @(negedge clk);
      check("abort_result_kept", result, ek.res);
      check("abort_stays_idle", busy, 0);
    end
    drain(120);
    last_op_cur = last;
  endtask

  task automatic reset_mid_exec();
    a_in = W'($urandom); b_in = W'($urandom); op_in = 3'($urandom_range(6)); auto_mode = 1'b0;
    start = 1'b1;
    wait_busy();
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_outputs",
          {result, n_out, z_out, c_out, v_out, op_cur, err, alu_a, alu_b, alu_op}, 0);
    check("rst_async_busy_done", {busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    last_op_cur = 0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {result, n_out, z_out, c_out, v_out, op_cur, err, alu_a, alu_b, alu_op}, 0);
    check("reset_busy_done", {busy, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    single_run(4'd3, 4'd5, 3'd0);
    single_run(4'd15, 4'd1, 3'd0);
    single_run(4'd2, 4'd5, 3'd1);
    single_run(4'd8, 4'd0, 3'd2);
    single_run(4'd9, 4'd4, 3'd7);
    start_held(4'd4, 4'd4, 3'd1);
    auto_run(4'd6, 4'd3, 7);
    auto_run(4'd6, 4'd3, 3);
    reset_mid_exec();

    repeat (24) single_run(W'($urandom), W'($urandom), 3'($urandom));
    repeat (4) auto_run(W'($urandom), W'($urandom), $urandom_range(7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
